// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch path.
// Decode and the top level reuse pc_t so PC widths stay consistent.
package fetch_pkg;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   typedef logic [DEFAULT_ADDR_WIDTH-1:0] pc_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences memory reads and
// hands fetched words to decode over a valid/ready handshake.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] PC_STEP = 1,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halted,
   output logic [31:0]           fetch_count
);

   fetch_state_t            r_state;
   fetch_state_t            w_nextState;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic [ADDR_WIDTH-1:0]   w_nextPc;
   logic [DATA_WIDTH-1:0]   r_instrData;
   logic [ADDR_WIDTH-1:0]   r_instrPc;
   logic [31:0]             r_fetchCount;
   logic                    w_capture;
   logic                    w_accept;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Redirect outranks memory completion and decode acceptance in every state.
   always_comb begin
      w_nextState = r_state;
      w_nextPc    = r_pc;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (redirect_valid) begin
               w_nextPc = redirect_pc;
            end else if (start) begin
               w_nextState = FETCH;
            end
         end
         FETCH: begin
            if (redirect_valid) begin
               w_nextPc = redirect_pc;
            end else if (mem_ack) begin
               w_capture   = 1'b1;
               w_nextPc    = r_pc + PC_STEP;
               w_nextState = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               w_nextPc    = redirect_pc;
               w_nextState = FETCH;
            end else if (instr_ready) begin
               w_accept    = 1'b1;
               w_nextState = (r_instrData == HALT_WORD) ? HALTED : FETCH;
            end
         end
         HALTED: begin
            if (redirect_valid) begin
               w_nextPc    = redirect_pc;
               w_nextState = FETCH;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_instrData  <= '0;
         r_instrPc    <= '0;
         r_fetchCount <= '0;
      end else begin
         r_pc <= w_nextPc;
         if (w_capture) begin
            r_instrData <= mem_rdata;
            r_instrPc   <= r_pc;
         end
         if (w_accept) begin
            r_fetchCount <= r_fetchCount + 32'd1;
         end
      end
   end

   assign mem_req     = (r_state == FETCH);
   assign instr_valid = (r_state == HOLD);
   assign halted      = (r_state == HALTED);
   assign mem_addr    = r_pc;
   assign pc          = r_pc;
   assign instr_data  = r_instrData;
   assign instr_pc    = r_instrPc;
   assign fetch_count = r_fetchCount;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the PC register and sequences reads from the instruction memory.
- Presents fetched words to decode over a valid/ready handshake.
- Supports redirect (branch/jump load), a start/halt lifecycle, and a retired-fetch counter.
- Sits between simple_memory and decode, and replaces the free-running PC in the top level.

Parameters:
- ADDR_WIDTH, 32, PC/memory address width.
- DATA_WIDTH, 32, instruction word width.
- PC_STEP, 1, PC increment per fetch (word-addressed memory).
- RESET_PC, 0, PC value after reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch once consumed.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  leave IDLE and begin fetching
- redirect_valid  input  1  load redirect_pc as the next fetch address
- redirect_pc  input  ADDR_WIDTH  redirect target
- mem_req  output  1  memory read request
- mem_addr  output  ADDR_WIDTH  read address (equals pc)
- mem_rdata  input  DATA_WIDTH  read data, valid when mem_ack=1
- mem_ack  input  1  read complete; may be tied high for combinational memory
- instr_valid  output  1  instr_data/instr_pc valid
- instr_ready  input  1  decode accepts the instruction
- instr_data  output  DATA_WIDTH  fetched instruction
- instr_pc  output  ADDR_WIDTH  address of instr_data
- pc  output  ADDR_WIDTH  current fetch address
- halted  output  1  HALT_WORD consumed; fetch stopped
- fetch_count  output  32  number of accepted instructions

Behaviour:
- All state is registered and updates on the rising clock edge. Reset is synchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, halted=0, fetch_count=0, mem_req=0.
- Reset asserted mid-operation discards any captured instruction. The reset values appear the cycle after the reset edge.
- States: IDLE, FETCH, HOLD, HALTED. Outputs are decoded from the state: mem_req=(state==FETCH), instr_valid=(state==HOLD), halted=(state==HALTED). mem_addr=pc at all times.
- IDLE: when start=1, go to FETCH. redirect_valid=1 loads pc but stays in IDLE.
- FETCH:
  - If redirect_valid=1: pc<=redirect_pc, stay in FETCH. Any mem_ack in the same cycle is discarded.
  - Else if mem_ack=1: instr_data<=mem_rdata, instr_pc<=pc, pc<=pc+PC_STEP, go to HOLD.
  - Else hold mem_req and pc, and stay in FETCH.
- HOLD: instr_data and instr_pc are stable while instr_valid=1 and instr_ready=0.
  - If redirect_valid=1: pc<=redirect_pc, go to FETCH. The held instruction is dropped and not counted, even if instr_ready=1.
  - Else if instr_ready=1: fetch_count<=fetch_count+1. If instr_data==HALT_WORD go to HALTED, else go to FETCH.
- HALTED: start is ignored. redirect_valid=1 sets pc<=redirect_pc, go to FETCH, and halted clears.
- Latency with mem_ack tied high and instr_ready high:
  - 1 cycle from entering FETCH to instr_valid.
  - Steady throughput of 1 instruction per 2 cycles.
- Arithmetic:
  - pc+PC_STEP wraps modulo 2^ADDR_WIDTH.
  - fetch_count wraps modulo 2^32.
- Priority, highest first: reset, redirect_valid, mem_ack/instr_ready.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum (IDLE, FETCH, HOLD, HALTED).
  - Default ADDR_WIDTH, DATA_WIDTH and HALT_WORD constants.
  - A pc_t typedef, also used by decode and the top level.
- No sub-module. The PC, next-PC logic and FSM are small enough to stay in one module.

Test Plan:
- Reset, then start at t0 with mem_ack=1, instr_ready=1, memory[i]=100+i -> instr_valid pulses every 2nd cycle with (instr_pc,instr_data) = (0,100),(1,101),(2,102); fetch_count=3 after the 3rd accept.
- Backpressure: instr_ready=0 for 4 cycles in HOLD with instr_pc=5 -> instr_valid=1, instr_data/instr_pc stable, pc=6, no mem_req; ready=1 -> fetch_count increments once, next instr_pc=6.
- Redirect in HOLD at instr_pc=3 with redirect_pc=40 and instr_ready=1 -> instruction dropped, fetch_count unchanged, next instr_pc=40.
- Slow memory, mem_ack 3 cycles after mem_req -> mem_req and mem_addr held for 3 cycles; redirect to 20 during the wait -> mem_addr=20 next cycle, first delivered instr_pc=20.
- memory[2]=HALT_WORD -> after the accept of instr_pc=2, halted=1, mem_req=0 and start is ignored; redirect_pc=0 -> halted=0, fetch resumes at 0.
- Wrap-around: redirect to 32'hFFFF_FFFF -> instr_pc=FFFF_FFFF, then instr_pc=0. Reset asserted in HOLD -> the next cycle shows all reset values.
